// File: rtl/tetris_pkg.sv
// Shared tetromino definitions: move codes and the per-shape cell offset table.
package tetris_pkg;

  typedef enum logic [2:0] {
    RIGHT = 3'd0,
    LEFT  = 3'd1,
    ROR   = 3'd2,
    ROL   = 3'd3,
    DOWN  = 3'd4
  } move_t;

  // SHAPE_OFFSETS[shape][rot][k] = {dr[1:0], dc[1:0]} inside the 4x4 bounding box.
  // Shapes 0..6 = I,O,T,S,Z,J,L; shape 7 is an invalid code and is never committed.
  localparam logic [3:0] SHAPE_OFFSETS [8][4][4] = '{
    '{'{4'd4, 4'd5, 4'd6, 4'd7}, '{4'd2, 4'd6, 4'd10, 4'd14},
      '{4'd8, 4'd9, 4'd10, 4'd11}, '{4'd1, 4'd5, 4'd9, 4'd13}},
    '{'{4'd1, 4'd2, 4'd5, 4'd6}, '{4'd1, 4'd2, 4'd5, 4'd6},
      '{4'd1, 4'd2, 4'd5, 4'd6}, '{4'd1, 4'd2, 4'd5, 4'd6}},
    '{'{4'd1, 4'd4, 4'd5, 4'd6}, '{4'd1, 4'd5, 4'd6, 4'd9},
      '{4'd4, 4'd5, 4'd6, 4'd9}, '{4'd1, 4'd4, 4'd5, 4'd9}},
    '{'{4'd1, 4'd2, 4'd4, 4'd5}, '{4'd1, 4'd5, 4'd6, 4'd10},
      '{4'd5, 4'd6, 4'd8, 4'd9}, '{4'd0, 4'd4, 4'd5, 4'd9}},
    '{'{4'd0, 4'd1, 4'd5, 4'd6}, '{4'd2, 4'd5, 4'd6, 4'd9},
      '{4'd4, 4'd5, 4'd9, 4'd10}, '{4'd1, 4'd4, 4'd5, 4'd8}},
    '{'{4'd0, 4'd4, 4'd5, 4'd6}, '{4'd1, 4'd2, 4'd5, 4'd9},
      '{4'd4, 4'd5, 4'd6, 4'd10}, '{4'd1, 4'd5, 4'd8, 4'd9}},
    '{'{4'd2, 4'd4, 4'd5, 4'd6}, '{4'd1, 4'd5, 4'd9, 4'd10},
      '{4'd4, 4'd5, 4'd6, 4'd8}, '{4'd0, 4'd1, 4'd5, 4'd9}},
    '{'{4'd0, 4'd0, 4'd0, 4'd0}, '{4'd0, 4'd0, 4'd0, 4'd0},
      '{4'd0, 4'd0, 4'd0, 4'd0}, '{4'd0, 4'd0, 4'd0, 4'd0}}
  };

endpackage

// File: rtl/piece_mover_if.sv
// Request/response and occupancy-read bundle between the game FSM side and piece_mover.
interface piece_mover_if #(
  parameter int unsigned GRID_W  = 10,
  parameter int unsigned GRID_H  = 20,
  parameter int unsigned COLOR_W = 3
);
  localparam int unsigned RowW = $clog2(GRID_H);
  localparam int unsigned ColW = $clog2(GRID_W);

  logic                     spawn_valid;
  logic [2:0]               spawn_shape;
  logic [COLOR_W-1:0]       spawn_color;
  logic                     move_valid;
  tetris_pkg::move_t        move;
  logic                     req_ready;
  logic                     occ_rd_en;
  logic [RowW-1:0]          occ_rd_row;
  logic [ColW-1:0]          occ_rd_col;
  logic                     occ_rd_data;
  logic                     done;
  logic                     ok;
  logic                     landed;
  logic                     top_out;
  logic                     piece_valid;
  logic [COLOR_W-1:0]       piece_color;
  logic [3:0][RowW-1:0]     cell_row;
  logic [3:0][ColW-1:0]     cell_col;

  modport master (
    output spawn_valid, spawn_shape, spawn_color, move_valid, move, occ_rd_data,
    input  req_ready, occ_rd_en, occ_rd_row, occ_rd_col, done, ok, landed, top_out,
    input  piece_valid, piece_color, cell_row, cell_col
  );

  modport slave (
    input  spawn_valid, spawn_shape, spawn_color, move_valid, move, occ_rd_data,
    output req_ready, occ_rd_en, occ_rd_row, occ_rd_col, done, ok, landed, top_out,
    output piece_valid, piece_color, cell_row, cell_col
  );
endinterface

// File: rtl/piece_mover.sv
// Active-tetromino owner: validates spawn/move requests against bounds and occupancy.
module piece_mover
  import tetris_pkg::*;
#(
  parameter int unsigned GRID_W  = 10,
  parameter int unsigned GRID_H  = 20,
  parameter int unsigned COLOR_W = 3
) (
  input logic         clk,
  input logic         n_rst,
  piece_mover_if.slave bus
);
  localparam int unsigned RowW   = $clog2(GRID_H);
  localparam int unsigned ColW   = $clog2(GRID_W);
  localparam int unsigned MaxDim = (GRID_W > GRID_H) ? GRID_W : GRID_H;
  localparam int unsigned SW     = $clog2(MaxDim) + 2;

  localparam logic signed [SW-1:0] One      = SW'(1);
  localparam logic signed [SW-1:0] RowLim   = SW'(GRID_H);
  localparam logic signed [SW-1:0] ColLim   = SW'(GRID_W);
  localparam logic signed [SW-1:0] SpawnCol = SW'((GRID_W - 4) / 2);

  typedef enum logic [1:0] {StIdle, StBound, StRead, StResult} state_e;

  state_e               state_q, state_d;
  logic [2:0]           shape_q, shape_d;
  logic [1:0]           rot_q, rot_d;
  logic [RowW-1:0]      orow_q, orow_d;
  logic [ColW-1:0]      ocol_q, ocol_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic                 piece_valid_q, piece_valid_d;
  logic                 top_out_q, top_out_d;
  logic [3:0][RowW-1:0] cell_row_q, cell_row_d;
  logic [3:0][ColW-1:0] cell_col_q, cell_col_d;
  logic                 req_spawn_q, req_spawn_d;
  move_t                req_move_q, req_move_d;
  logic [2:0]           req_shape_q, req_shape_d;
  logic [COLOR_W-1:0]   req_color_q, req_color_d;
  logic [1:0]           cand_rot_q, cand_rot_d;
  logic [RowW-1:0]      cand_orow_q, cand_orow_d;
  logic [ColW-1:0]      cand_ocol_q, cand_ocol_d;
  logic [3:0][RowW-1:0] cand_row_q, cand_row_d;
  logic [3:0][ColW-1:0] cand_col_q, cand_col_d;
  logic                 fail_q, fail_d;
  logic [2:0]           rd_cnt_q, rd_cnt_d;

  logic signed [SW-1:0] base_row, base_col, cell_r, cell_c;
  logic [1:0]           new_rot;
  logic [2:0]           cand_shape;
  logic [3:0]           off;
  logic                 cand_bad;
  logic [3:0][RowW-1:0] cand_row_c;
  logic [3:0][ColW-1:0] cand_col_c;

  logic                 occ_rd_en, done, ok, landed;
  logic [RowW-1:0]      occ_rd_row;
  logic [ColW-1:0]      occ_rd_col;

  // Candidate origin/rotation and cells for the latched request, with bounds verdict.
  always_comb begin
    base_row   = signed'(SW'(orow_q));
    base_col   = signed'(SW'(ocol_q));
    new_rot    = rot_q;
    cand_shape = shape_q;
    cand_bad   = ~piece_valid_q;
    cell_r     = '0;
    cell_c     = '0;
    off        = '0;
    cand_row_c = '0;
    cand_col_c = '0;
    if (req_spawn_q) begin
      base_row   = '0;
      base_col   = SpawnCol;
      new_rot    = 2'd0;
      cand_shape = req_shape_q;
      cand_bad   = (req_shape_q == 3'd7);
    end else begin
      case (req_move_q)
        RIGHT:   base_col = base_col + One;
        LEFT:    base_col = base_col - One;
        ROR:     new_rot  = rot_q + 2'd1;
        ROL:     new_rot  = rot_q - 2'd1;
        DOWN:    base_row = base_row + One;
        default: cand_bad = 1'b1;
      endcase
    end
    // A negative origin cannot be stored, so it is rejected even if the cells fit.
    if (base_row < 0 || base_col < 0) cand_bad = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      off    = SHAPE_OFFSETS[cand_shape][new_rot][k[1:0]];
      cell_r = base_row + signed'(SW'(off[3:2]));
      cell_c = base_col + signed'(SW'(off[1:0]));
      if (cell_r < 0 || cell_r >= RowLim || cell_c < 0 || cell_c >= ColLim) cand_bad = 1'b1;
      cand_row_c[k[1:0]] = cell_r[RowW-1:0];
      cand_col_c[k[1:0]] = cell_c[ColW-1:0];
    end
  end

  // Request FSM: next state, piece commit and occupancy read sequencing.
  always_comb begin
    state_d       = state_q;
    shape_d       = shape_q;
    rot_d         = rot_q;
    orow_d        = orow_q;
    ocol_d        = ocol_q;
    color_d       = color_q;
    piece_valid_d = piece_valid_q;
    top_out_d     = top_out_q;
    cell_row_d    = cell_row_q;
    cell_col_d    = cell_col_q;
    req_spawn_d   = req_spawn_q;
    req_move_d    = req_move_q;
    req_shape_d   = req_shape_q;
    req_color_d   = req_color_q;
    cand_rot_d    = cand_rot_q;
    cand_orow_d   = cand_orow_q;
    cand_ocol_d   = cand_ocol_q;
    cand_row_d    = cand_row_q;
    cand_col_d    = cand_col_q;
    fail_d        = fail_q;
    rd_cnt_d      = rd_cnt_q;
    occ_rd_en     = 1'b0;
    occ_rd_row    = '0;
    occ_rd_col    = '0;
    done          = 1'b0;
    ok            = 1'b0;
    landed        = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Spawn has priority; a simultaneous move is simply not accepted.
        if (bus.spawn_valid) begin
          req_spawn_d = 1'b1;
          req_shape_d = bus.spawn_shape;
          req_color_d = bus.spawn_color;
          state_d     = StBound;
        end else if (bus.move_valid) begin
          req_spawn_d = 1'b0;
          req_move_d  = bus.move;
          state_d     = StBound;
        end
      end
      StBound: begin
        cand_rot_d  = new_rot;
        cand_orow_d = base_row[RowW-1:0];
        cand_ocol_d = base_col[ColW-1:0];
        cand_row_d  = cand_row_c;
        cand_col_d  = cand_col_c;
        fail_d      = cand_bad;
        rd_cnt_d    = 3'd0;
        state_d     = cand_bad ? StResult : StRead;
      end
      StRead: begin
        // Read cell k in slot k, sample its datum in slot k+1.
        if (rd_cnt_q != 3'd4) begin
          occ_rd_en  = 1'b1;
          occ_rd_row = cand_row_q[rd_cnt_q[1:0]];
          occ_rd_col = cand_col_q[rd_cnt_q[1:0]];
        end
        if (rd_cnt_q != 3'd0) fail_d = fail_q | bus.occ_rd_data;
        rd_cnt_d = rd_cnt_q + 3'd1;
        if (rd_cnt_q == 3'd4) state_d = StResult;
      end
      StResult: begin
        done    = 1'b1;
        ok      = ~fail_q;
        landed  = fail_q & ~req_spawn_q & (req_move_q == DOWN) & piece_valid_q;
        state_d = StIdle;
        if (!fail_q) begin
          orow_d        = cand_orow_q;
          ocol_d        = cand_ocol_q;
          rot_d         = cand_rot_q;
          cell_row_d    = cand_row_q;
          cell_col_d    = cand_col_q;
          piece_valid_d = 1'b1;
          if (req_spawn_q) begin
            shape_d   = req_shape_q;
            color_d   = req_color_q;
            top_out_d = 1'b0;
          end
        end else if (req_spawn_q) begin
          top_out_d     = 1'b1;
          piece_valid_d = 1'b0;
        end else if (landed) begin
          piece_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= StIdle;
      shape_q       <= '0;
      rot_q         <= '0;
      orow_q        <= '0;
      ocol_q        <= '0;
      color_q       <= '0;
      piece_valid_q <= 1'b0;
      top_out_q     <= 1'b0;
      cell_row_q    <= '0;
      cell_col_q    <= '0;
      req_spawn_q   <= 1'b0;
      req_move_q    <= RIGHT;
      req_shape_q   <= '0;
      req_color_q   <= '0;
      cand_rot_q    <= '0;
      cand_orow_q   <= '0;
      cand_ocol_q   <= '0;
      cand_row_q    <= '0;
      cand_col_q    <= '0;
      fail_q        <= 1'b0;
      rd_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      shape_q       <= shape_d;
      rot_q         <= rot_d;
      orow_q        <= orow_d;
      ocol_q        <= ocol_d;
      color_q       <= color_d;
      piece_valid_q <= piece_valid_d;
      top_out_q     <= top_out_d;
      cell_row_q    <= cell_row_d;
      cell_col_q    <= cell_col_d;
      req_spawn_q   <= req_spawn_d;
      req_move_q    <= req_move_d;
      req_shape_q   <= req_shape_d;
      req_color_q   <= req_color_d;
      cand_rot_q    <= cand_rot_d;
      cand_orow_q   <= cand_orow_d;
      cand_ocol_q   <= cand_ocol_d;
      cand_row_q    <= cand_row_d;
      cand_col_q    <= cand_col_d;
      fail_q        <= fail_d;
      rd_cnt_q      <= rd_cnt_d;
    end
  end

  assign bus.req_ready   = (state_q == StIdle);
  assign bus.occ_rd_en   = occ_rd_en;
  assign bus.occ_rd_row  = occ_rd_row;
  assign bus.occ_rd_col  = occ_rd_col;
  assign bus.done        = done;
  assign bus.ok          = ok;
  assign bus.landed      = landed;
  assign bus.top_out     = top_out_q;
  assign bus.piece_valid = piece_valid_q;
  assign bus.piece_color = color_q;
  assign bus.cell_row    = cell_row_q;
  assign bus.cell_col    = cell_col_q;

endmodule

// File: tb/tb_piece_mover.sv
// Directed bench for piece_mover on a 10x20 grid with a behavioural occupancy RAM.
module tb_piece_mover;
  import tetris_pkg::*;

  localparam int unsigned GW = 10;
  localparam int unsigned GH = 20;
  localparam int unsigned CWd = 3;
  localparam int R = 0, L = 1, RR = 2, RL = 3, D = 4;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;

  piece_mover_if #(.GRID_W(GW), .GRID_H(GH), .COLOR_W(CWd)) bus ();

  piece_mover #(.GRID_W(GW), .GRID_H(GH), .COLOR_W(CWd)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  logic occ [GH][GW];

  // Occupancy RAM: one-cycle read latency.
  always @(posedge clk) begin
    bus.occ_rd_data <= bus.occ_rd_en ? occ[bus.occ_rd_row][bus.occ_rd_col] : 1'b0;
  end

  typedef struct {
    int sp; int shape; int color; int mvv; int mv;
    int occ_op; int occ_r; int occ_c;
    int lat; int ok; int landed; int nrd;
    int pv; int top; int pcol;
    logic [31:0] rows; logic [31:0] cols;
  } vec_t;

  vec_t vq[$];
  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  function automatic logic [31:0] c4(int a, int b, int c, int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic logic [31:0] act_rows();
    return {8'(bus.cell_row[3]), 8'(bus.cell_row[2]), 8'(bus.cell_row[1]), 8'(bus.cell_row[0])};
  endfunction

  function automatic logic [31:0] act_cols();
    return {8'(bus.cell_col[3]), 8'(bus.cell_col[2]), 8'(bus.cell_col[1]), 8'(bus.cell_col[0])};
  endfunction

  task automatic add(input int sp, shape, color, mvv, mv, occ_op, occ_r, occ_c,
                     input int lat, ok, landed, nrd, pv, top, pcol,
                     input logic [31:0] rows, cols);
    vec_t v;
    v = '{sp, shape, color, mvv, mv, occ_op, occ_r, occ_c, lat, ok, landed, nrd,
          pv, top, pcol, rows, cols};
    vq.push_back(v);
  endtask

  task automatic clear_occ();
    for (int r = 0; r < int'(GH); r++)
      for (int c = 0; c < int'(GW); c++) occ[r][c] = 1'b0;
  endtask

  // One request; latency counted from the accept edge, bounded to 20 cycles.
  task automatic do_req(input int sp, shp, colr, mvv, mv,
                        output int lat, output int rok, output int rland,
                        output int nrd, output int rdy1);
    @(negedge clk);
    bus.spawn_valid = sp[0];
    bus.spawn_shape = shp[2:0];
    bus.spawn_color = colr[2:0];
    bus.move_valid  = mvv[0];
    bus.move        = move_t'(mv[2:0]);
    @(posedge clk);
    lat = -1; rok = 0; rland = 0; nrd = 0; rdy1 = 1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.spawn_valid = 1'b0;
        bus.move_valid  = 1'b0;
        rdy1 = int'(bus.req_ready);
      end
      if (bus.occ_rd_en) nrd++;
      if (bus.done) begin
        lat   = c;
        rok   = int'(bus.ok);
        rland = int'(bus.landed);
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int lat, rok, rland, nrd, rdy1, ndone;
    string nm;

    bus.spawn_valid = 1'b0;
    bus.spawn_shape = '0;
    bus.spawn_color = '0;
    bus.move_valid  = 1'b0;
    bus.move        = RIGHT;
    clear_occ();

    #1 n_rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst req_ready", int'(bus.req_ready), 1);
    chk("rst done", int'(bus.done), 0);
    chk("rst ok", int'(bus.ok), 0);
    chk("rst landed", int'(bus.landed), 0);
    chk("rst top_out", int'(bus.top_out), 0);
    chk("rst piece_valid", int'(bus.piece_valid), 0);
    chk("rst piece_color", int'(bus.piece_color), 0);
    chk("rst occ_rd_en", int'(bus.occ_rd_en), 0);
    chk("rst cell_row", int'(act_rows()), 0);
    chk("rst cell_col", int'(act_cols()), 0);
    n_rst = 1'b1;

    //  sp shp col mvv mv  op r  c  lat ok ld nrd pv top pc  rows / cols
    add(1, 2, 3, 0, R,  0, 0, 0, 7, 1, 0, 4, 1, 0, 3, c4(0, 1, 1, 1), c4(4, 3, 4, 5));
    add(0, 0, 0, 1, L,  0, 0, 0, 7, 1, 0, 4, 1, 0, 3, c4(0, 1, 1, 1), c4(3, 2, 3, 4));
    add(0, 0, 0, 1, L,  0, 0, 0, 7, 1, 0, 4, 1, 0, 3, c4(0, 1, 1, 1), c4(2, 1, 2, 3));
    add(0, 0, 0, 1, L,  0, 0, 0, 7, 1, 0, 4, 1, 0, 3, c4(0, 1, 1, 1), c4(1, 0, 1, 2));
    add(0, 0, 0, 1, L,  0, 0, 0, 2, 0, 0, 0, 1, 0, 3, c4(0, 1, 1, 1), c4(1, 0, 1, 2));
    add(0, 0, 0, 1, R,  0, 0, 0, 7, 1, 0, 4, 1, 0, 3, c4(0, 1, 1, 1), c4(2, 1, 2, 3));
    add(0, 0, 0, 1, R,  0, 0, 0, 7, 1, 0, 4, 1, 0, 3, c4(0, 1, 1, 1), c4(3, 2, 3, 4));
    add(0, 0, 0, 1, R,  0, 0, 0, 7, 1, 0, 4, 1, 0, 3, c4(0, 1, 1, 1), c4(4, 3, 4, 5));
    add(0, 0, 0, 1, D,  1, 5, 4, 7, 1, 0, 4, 1, 0, 3, c4(1, 2, 2, 2), c4(4, 3, 4, 5));
    add(0, 0, 0, 1, D,  0, 0, 0, 7, 1, 0, 4, 1, 0, 3, c4(2, 3, 3, 3), c4(4, 3, 4, 5));
    add(0, 0, 0, 1, D,  0, 0, 0, 7, 1, 0, 4, 1, 0, 3, c4(3, 4, 4, 4), c4(4, 3, 4, 5));
    add(0, 0, 0, 1, D,  0, 0, 0, 7, 0, 1, 4, 0, 0, 3, c4(3, 4, 4, 4), c4(4, 3, 4, 5));
    add(1, 2, 3, 0, R,  1, 0, 4, 7, 0, 0, 4, 0, 1, 3, c4(3, 4, 4, 4), c4(4, 3, 4, 5));
    add(0, 0, 0, 1, RR, 0, 0, 0, 2, 0, 0, 0, 0, 1, 3, c4(3, 4, 4, 4), c4(4, 3, 4, 5));
    add(1, 0, 5, 0, R,  0, 0, 0, 7, 1, 0, 4, 1, 0, 5, c4(1, 1, 1, 1), c4(3, 4, 5, 6));
    add(0, 0, 0, 1, RR, 2, 0, 0, 7, 1, 0, 4, 1, 0, 5, c4(0, 1, 2, 3), c4(5, 5, 5, 5));
    add(0, 0, 0, 1, RR, 0, 0, 0, 7, 1, 0, 4, 1, 0, 5, c4(2, 2, 2, 2), c4(3, 4, 5, 6));
    add(0, 0, 0, 1, RR, 0, 0, 0, 7, 1, 0, 4, 1, 0, 5, c4(0, 1, 2, 3), c4(4, 4, 4, 4));
    add(0, 0, 0, 1, RR, 0, 0, 0, 7, 1, 0, 4, 1, 0, 5, c4(1, 1, 1, 1), c4(3, 4, 5, 6));
    add(0, 0, 0, 1, RL, 0, 0, 0, 7, 1, 0, 4, 1, 0, 5, c4(0, 1, 2, 3), c4(4, 4, 4, 4));
    add(0, 0, 0, 1, 5,  0, 0, 0, 2, 0, 0, 0, 1, 0, 5, c4(0, 1, 2, 3), c4(4, 4, 4, 4));
    add(1, 7, 6, 0, R,  0, 0, 0, 2, 0, 0, 0, 0, 1, 5, c4(0, 1, 2, 3), c4(4, 4, 4, 4));
    add(1, 1, 1, 0, R,  0, 0, 0, 7, 1, 0, 4, 1, 0, 1, c4(0, 0, 1, 1), c4(4, 5, 4, 5));
    add(1, 3, 2, 1, D,  0, 0, 0, 7, 1, 0, 4, 1, 0, 2, c4(0, 0, 1, 1), c4(4, 5, 3, 4));

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      if (v.occ_op == 1) occ[v.occ_r][v.occ_c] = 1'b1;
      else if (v.occ_op == 2) clear_occ();
      do_req(v.sp, v.shape, v.color, v.mvv, v.mv, lat, rok, rland, nrd, rdy1);
      nm = $sformatf("v%0d", i);
      chk({nm, " latency"}, lat, v.lat);
      chk({nm, " ok"}, rok, v.ok);
      chk({nm, " landed"}, rland, v.landed);
      chk({nm, " reads"}, nrd, v.nrd);
      chk({nm, " busy ready"}, rdy1, 0);
      @(negedge clk);
      chk({nm, " ready after"}, int'(bus.req_ready), 1);
      chk({nm, " piece_valid"}, int'(bus.piece_valid), v.pv);
      chk({nm, " top_out"}, int'(bus.top_out), v.top);
      chk({nm, " color"}, int'(bus.piece_color), v.pcol);
      chk({nm, " rows"}, int'(act_rows()), int'(v.rows));
      chk({nm, " cols"}, int'(act_cols()), int'(v.cols));
    end

    // The simultaneous move from the last vector must not run afterwards.
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("both valid extra done", ndone, 0);

    // Requests held while busy are ignored; only the accepted RIGHT completes.
    bus.move_valid = 1'b1;
    bus.move       = RIGHT;
    @(posedge clk);
    ndone = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c <= 5) begin
        bus.spawn_valid = 1'b1;
        bus.spawn_shape = 3'd0;
        bus.spawn_color = 3'd7;
        bus.move_valid  = 1'b1;
      end else begin
        bus.spawn_valid = 1'b0;
        bus.move_valid  = 1'b0;
      end
      if (bus.done) ndone++;
    end
    chk("busy requests done count", ndone, 1);
    chk("busy requests cols", int'(act_cols()), int'(c4(5, 6, 4, 5)));
    chk("busy requests color", int'(bus.piece_color), 2);

    // Reset in the middle of the occupancy reads.
    @(negedge clk);
    bus.spawn_valid = 1'b1;
    bus.spawn_shape = 3'd1;
    bus.spawn_color = 3'd4;
    @(posedge clk);
    @(negedge clk);
    bus.spawn_valid = 1'b0;
    @(negedge clk);
    chk("pre-reset reading", int'(bus.occ_rd_en), 1);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("mid rst req_ready", int'(bus.req_ready), 1);
    chk("mid rst done", int'(bus.done), 0);
    chk("mid rst occ_rd_en", int'(bus.occ_rd_en), 0);
    chk("mid rst piece_valid", int'(bus.piece_valid), 0);
    chk("mid rst color", int'(bus.piece_color), 0);
    chk("mid rst cell_col", int'(act_cols()), 0);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 2) n_rst = 1'b1;
      if (bus.done) ndone++;
    end
    chk("mid rst no done", ndone, 0);

    do_req(1, 2, 3, 0, R, lat, rok, rland, nrd, rdy1);
    chk("post rst latency", lat, 7);
    chk("post rst ok", rok, 1);
    chk("post rst reads", nrd, 4);
    @(negedge clk);
    chk("post rst piece_valid", int'(bus.piece_valid), 1);
    chk("post rst rows", int'(act_rows()), int'(c4(0, 1, 1, 1)));
    chk("post rst cols", int'(act_cols()), int'(c4(4, 3, 4, 5)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/piece_mover.md
Name: piece_mover

Overview:
- Sequential, parametrised successor to the combinational per-frame tracker.
- Owns the single active tetromino: its shape, rotation, origin and colour.
- Accepts spawn and move requests through a valid/ready handshake and checks each candidate position against playfield bounds and against the occupancy store, reading one cell per cycle.
- Commits the move or rejects it, and reports landing and top-out to the game FSM. Sits between the game FSM and the playfield occupancy RAM.

Parameters:
GRID_W, 10, playfield columns (4..32)
GRID_H, 20, playfield rows (4..32)
COLOR_W, 3, colour code width; 0 is reserved for empty

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
spawn_valid  in  1  request a new piece
spawn_shape  in  3  0..6 = I,O,T,S,Z,J,L; 7 is invalid and rejected
spawn_color  in  COLOR_W  colour of the new piece
move_valid  in  1  request a move
move  in  move_t  RIGHT, LEFT, ROR, ROL or DOWN (tetris_pkg); other codes are rejected
req_ready  out  1  high only in IDLE
occ_rd_en  out  1  occupancy read strobe
occ_rd_row  out  $clog2(GRID_H)  read row
occ_rd_col  out  $clog2(GRID_W)  read column
occ_rd_data  in  1  cell occupied; valid exactly 1 cycle after occ_rd_en
done  out  1  one-cycle pulse when a request finishes
ok  out  1  qualified by done: 1 = committed, 0 = rejected
landed  out  1  qualified by done: a DOWN was rejected
top_out  out  1  sticky: a spawn collided
piece_valid  out  1  an active piece exists
piece_color  out  COLOR_W  colour of the active piece
cell_row  out  4 x $clog2(GRID_H)  rows of the 4 active cells
cell_col  out  4 x $clog2(GRID_W)  columns of the 4 active cells

Behaviour:
- Reset (async, n_rst low):
  - State returns to IDLE.
  - All outputs are 0 except req_ready=1.
  - Origin, rot and shape registers clear to 0.
  - Reset mid-operation abandons the request with no done pulse.
- Piece model:
  - Each cell = origin (orow, ocol) + offset (dr, dc), with dr and dc in 0..3.
  - Offsets come from the SHAPE_OFFSETS[shape][rot][k] table, a new constant added to tetris_pkg.
  - cell_row and cell_col are driven from registered state, valid when piece_valid=1.
- Candidate position by request:
  - Spawn: orow=0, ocol=(GRID_W-4)/2, rot=0.
  - RIGHT: ocol+1. LEFT: ocol-1.
  - ROR: rot+1 mod 4. ROL: rot-1 mod 4.
  - DOWN: orow+1.
- Bounds arithmetic:
  - Performed at width $clog2(max)+2, signed.
  - A candidate cell is out of bounds if its row is <0 or >=GRID_H, or its column is <0 or >=GRID_W.
  - LEFT with ocol=0 is out of bounds; it must not wrap.
- FSM states: IDLE, BOUND, READ, RESULT.
  - IDLE: accept on valid && req_ready. If spawn_valid and move_valid are both high, spawn wins and the move is not accepted. A move with piece_valid=0 is accepted and rejected (done, ok=0) in RESULT. Go to BOUND.
  - BOUND (1 cycle): latch the 4 candidate cells. If any cell is out of bounds, or shape=7, or the move code is illegal, go to RESULT with fail. Otherwise go to READ.
  - READ: issue occ_rd_en for cells k=0..3 on consecutive cycles. OR-accumulate occ_rd_data, sampled one cycle after each read. Leave READ after the 4th datum is sampled (5 cycles total).
  - RESULT (1 cycle):
    - Pulse done.
    - ok=1 if there was no fail; in that case commit origin and rot, set piece_valid=1 and load the colour on spawn.
    - On fail:
      - Spawn fail: top_out=1 and piece_valid=0.
      - DOWN fail: landed=1; piece_valid is cleared the same cycle, so the FSM writes the piece into the grid.
      - Other move fail: state unchanged.
- Latency (accept edge = cycle 0):
  - Out-of-bounds request: done in cycle 2.
  - Full check: done in cycle 7.
  - req_ready is low from cycle 1 through the done cycle and is high again the cycle after done.
- top_out clears only on reset or on an accepted spawn that succeeds.
- The block never writes the occupancy store; the active piece is not assumed present in it.

Test Plan:
- Reset, then spawn T (shape 2, colour 3) into an empty 10x20 grid → done at cycle 7, ok=1, origin (0,3), 4 reads observed, piece_valid=1, piece_color=3.
- Place the piece at ocol=0, then request LEFT → done at cycle 2, ok=0, no occ_rd_en, cell_col unchanged.
- Pre-load occupancy (5,4)=1 with a piece directly above it, then request DOWN → done with ok=0 and landed=1, piece_valid falls; then spawn with (0,4) occupied → top_out=1 and stays high until the next successful spawn.
- Four ROR requests on an I piece in open space → each ok=1; after the fourth, rot=0 and the cells match the initial set; one ROL then matches rot=3.
- spawn_valid and move_valid high together in IDLE → only the spawn is performed; requests asserted while req_ready=0 produce no done.
- Assert n_rst during READ → outputs are at reset values immediately with no done pulse; the next spawn completes normally.
